pixel_streamer: RTL and testbench
=================================

# pixel_streamer

Frame source for the edge-detection pipeline. Reads one IMG_WIDTH x IMG_HEIGHT 8-bit grayscale frame, raster order, from a synchronous-read image memory. Emits it as a valid/ready pixel stream into the first pixel_loader, tagging each pixel with row, column and end-of-line / end-of-frame markers. Replaces bench-driven pixel injection so the filter chain can run from on-chip image storage with downstream back-pressure.

## Interface
Parameters:
- IMG_WIDTH, 512, pixels per line
- IMG_HEIGHT, 512, lines per frame
- ADDR_W, 18, memory address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT

Ports:
- clk  input  1  single clock; all logic on posedge
- rstN  input  1  synchronous, active-low reset
- start  input  1  frame request; sampled only in IDLE
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  read address, row*IMG_WIDTH+col
- mem_rd_data  input  8  read data, valid exactly 1 cycle after mem_rd_en
- pixel_out  output  8  stream pixel
- pixel_out_valid  output  1  stream valid
- pixel_ready  input  1  downstream ready
- pixel_col  output  16  column of pixel_out
- pixel_row  output  16  row of pixel_out
- end_of_line  output  1  pixel_out is last of its line
- end_of_frame  output  1  pixel_out is last of frame
- busy  output  1  high in STREAM and DRAIN
- done  output  1  one-cycle pulse after last pixel accepted

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE to STREAM: on start. Read address counter cleared to 0.
- STREAM: issue a read when (fifo_count + inflight - pop) < 2. pop = pixel_out_valid && pixel_ready. Address increments per issued read.
- STREAM to DRAIN: in the cycle the read of address W*H-1 issues.
- DRAIN to DONE: no reads issued. Transition when the end_of_frame pixel is accepted.
- DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- start asserted in the DONE cycle is ignored. It is honored only if still high once IDLE is reached.
- Returned read data enters a 2-entry FIFO. The FIFO head drives pixel_out, pixel_col, pixel_row, end_of_line and end_of_frame.
- Stream rule: once pixel_out_valid is high, it and all tag outputs hold stable until accepted.
- Output column/row counters advance on each pop.
  - Column wraps from IMG_WIDTH-1 to 0 and increments row.
  - Row and column both clear after the end_of_frame pop.
- end_of_line = (col == IMG_WIDTH-1).
- end_of_frame = end_of_line && (row == IMG_HEIGHT-1).
- FIFO can never overflow: the credit rule counts in-flight reads. A write to a full FIFO is a design error; the bench asserts on it.
- Reset value of every output is 0.
- Reset mid-frame: FSM returns to IDLE next edge. FIFO, counters and inflight flag clear. A read returning after reset is discarded.

## Timing
- start sampled at edge E0.
- mem_rd_en=1 with mem_addr=0 during cycle E0..E1.
- Data captured at E2; pixel_out_valid=1 from E2.
- With pixel_ready held high: one pixel per cycle, W*H consecutive valid cycles, zero bubbles.
- done pulses in the cycle after the last accept.
- pixel_ready low for N cycles: pixel_out frozen. FIFO fills to 2; reads stop.
- Resume: valid continues without a bubble; data order is preserved.
- Latency from read issue to valid data output is 2 cycles (empty FIFO).

## Structure
- Shared package canny_pkg holds:
  - streamer state enum (IDLE, STREAM, DRAIN, DONE)
  - default IMG_WIDTH/IMG_HEIGHT localparams, also used by pixel_loader
- One sub-module: pixel_skid_fifo. 2-entry, 8+tag bits wide, push/pop/count, show-ahead output.
- Credit logic, address counter, FSM and output tag counters live in pixel_streamer.

## Test plan
- Full-throughput frame, IMG_WIDTH=4, IMG_HEIGHT=3, memory holds value = address. Pulse start, pixel_ready=1 → pixels 0..11 on 12 consecutive cycles from E2. end_of_line on 3, 7, 11; end_of_frame only on 11; done one cycle later; busy falls with done.
- Back-pressure: pixel_ready toggles 1,0,0,1 repeating → every pixel delivered once in order. Data/tags stable while stalled; mem_rd_en never leaves more than 2 entries pending.
- Long stall: pixel_ready=0 for 20 cycles mid-line → FIFO count 2. No further mem_rd_en; on release the next pixel has the correct column.
- Start handling: start held high through a whole frame → exactly one frame, then a second frame begins after IDLE. start pulsed during STREAM → no effect.
- Reset mid-frame: rstN=0 at pixel 5 → all outputs 0 next cycle. New start yields pixel 0 with row=0, col=0.
- Default 512x512 with image-file memory → 262144 pixels. end_of_frame once; output file matches input byte-for-byte.

Source files
------------

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared types and default frame geometry for the edge-detection pipeline
package canny_pkg;
    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} streamer_state_t;

    // One buffered pixel: grey value plus the line/frame markers it carries downstream
    typedef struct packed {
        logic       eol;
        logic       eof;
        logic [7:0] pix;
    } pixel_entry_t;

    localparam int PIXEL_ENTRY_W = $bits(pixel_entry_t);
endpackage

// File: rtl/pixel_skid_fifo.sv
// rtl/pixel_skid_fifo.sv - 2-entry show-ahead FIFO holding returned pixels and their tags
module pixel_skid_fifo #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
endmodule

// File: rtl/pixel_streamer.sv
// rtl/pixel_streamer.sv - reads one raster frame from image memory and streams it with row/col/eol/eof tags
module pixel_streamer
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_W     = 18
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        pixel_out,
    output logic              pixel_out_valid,
    input  logic              pixel_ready,
    output logic [15:0]       pixel_col,
    output logic [15:0]       pixel_row,
    output logic              end_of_line,
    output logic              end_of_frame,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [15:0]       LAST_COL  = 16'(IMG_WIDTH - 1);

    streamer_state_t          state, state_nxt;
    logic [ADDR_W-1:0]        rd_addr;
    logic [15:0]              rd_col;
    logic [15:0]              out_col;
    logic [15:0]              out_row;
    logic                     inflight;
    logic                     inflight_eol;
    logic                     inflight_eof;
    logic [1:0]               fifo_count;
    logic [2:0]               pending;
    logic                     pop;
    logic                     issue;
    pixel_entry_t             push_entry;
    pixel_entry_t             head_entry;
    logic [PIXEL_ENTRY_W-1:0] head_bits;

    // Credit: entries already buffered plus the read still in flight must leave room after this pop
    assign pop     = pixel_out_valid && pixel_ready;
    assign pending = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    assign issue   = (state == STREAM) && (pending < 3'd2);

    assign mem_rd_en = issue;
    assign mem_addr  = rd_addr;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (issue && (rd_addr == LAST_ADDR)) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && head_entry.eof) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state        <= IDLE;
            rd_addr      <= '0;
            rd_col       <= '0;
            inflight     <= 1'b0;
            inflight_eol <= 1'b0;
            inflight_eof <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) begin
                inflight_eol <= (rd_col == LAST_COL);
                inflight_eof <= (rd_addr == LAST_ADDR);
                rd_addr      <= rd_addr + ADDR_W'(1);
                rd_col       <= (rd_col == LAST_COL) ? 16'd0 : rd_col + 16'd1;
            end
            if ((state == IDLE) && start) begin
                rd_addr <= '0;
                rd_col  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            out_col <= '0;
            out_row <= '0;
        end else if (pop) begin
            if (head_entry.eof) begin
                out_col <= '0;
                out_row <= '0;
            end else if (out_col == LAST_COL) begin
                out_col <= '0;
                out_row <= out_row + 16'd1;
            end else begin
                out_col <= out_col + 16'd1;
            end
        end
    end

    assign push_entry = '{eol: inflight_eol, eof: inflight_eof, pix: mem_rd_data};

    pixel_skid_fifo #(
        .DATA_W(PIXEL_ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rstN     (rstN),
        .push     (inflight),
        .push_data(push_entry),
        .pop      (pop),
        .head_data(head_bits),
        .count    (fifo_count)
    );

    assign head_entry      = pixel_entry_t'(head_bits);
    assign pixel_out_valid = (fifo_count != 2'd0);
    assign pixel_out       = head_entry.pix;
    assign end_of_line     = head_entry.eol;
    assign end_of_frame    = head_entry.eof;
    assign pixel_col       = out_col;
    assign pixel_row       = out_row;
endmodule

// File: tb/tb_pixel_streamer.sv
// tb/tb_pixel_streamer.sv - directed self-checking bench for pixel_streamer on a 4x3 frame
`timescale 1ns/1ps
module tb_pixel_streamer;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data = 8'h00;
    logic [7:0]    pixel_out;
    logic          pixel_out_valid;
    logic          pixel_ready = 1'b0;
    logic [15:0]   pixel_col;
    logic [15:0]   pixel_row;
    logic          end_of_line;
    logic          end_of_frame;
    logic          busy;
    logic          done;
    logic [41:0]   act_tuple;

    int compared   = 0;
    int mismatched = 0;
    int ovf_events = 0;

    pixel_streamer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW)
    ) dut (
        .clk            (clk),
        .rstN           (rstN),
        .start          (start),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .pixel_out      (pixel_out),
        .pixel_out_valid(pixel_out_valid),
        .pixel_ready    (pixel_ready),
        .pixel_col      (pixel_col),
        .pixel_row      (pixel_row),
        .end_of_line    (end_of_line),
        .end_of_frame   (end_of_frame),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Image memory holds 0x40 + address, so pixel 0 is distinguishable from the reset value
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {4'h4, mem_addr};
    end

    always @(negedge clk) begin
        if (rstN && dut.inflight && dut.fifo_count == 2'd2 && !(pixel_out_valid && pixel_ready)) begin
            $display("FAIL fifo_overflow: push into full fifo at %0t", $time);
            ovf_events++;
        end
    end

    assign act_tuple = {pixel_out, pixel_col, pixel_row, end_of_line, end_of_frame};

    function automatic logic [41:0] exp_tuple(input int k);
        return {8'h40 + 8'(k), 16'(k % W), 16'(k / W), (k % W) == W - 1, k == NPIX - 1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (done) seen = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; pixel_ready = 1'b0;
        repeat (3) tick();
        compared++;
        if ({mem_rd_en, mem_addr} !== '0) begin
            mismatched++; $display("FAIL reset_mem: got %h want 0", {mem_rd_en, mem_addr});
        end
        compared++;
        if ({pixel_out_valid, pixel_out} !== '0) begin
            mismatched++; $display("FAIL reset_pixel: got %h want 0", {pixel_out_valid, pixel_out});
        end
        compared++;
        if ({pixel_col, pixel_row, end_of_line, end_of_frame} !== '0) begin
            mismatched++; $display("FAIL reset_tags: got %h want 0", {pixel_col, pixel_row, end_of_line, end_of_frame});
        end
        compared++;
        if ({busy, done} !== 2'b00) begin
            mismatched++; $display("FAIL reset_status: got %b want 00", {busy, done});
        end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        pixel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        compared++;
        if ({mem_rd_en, mem_addr, busy, pixel_out_valid} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            mismatched++; $display("FAIL first_read: got en=%b addr=%0d busy=%b valid=%b want 1 0 1 0",
                                   mem_rd_en, mem_addr, busy, pixel_out_valid);
        end
        tick();
        compared++;
        if (pixel_out_valid !== 1'b0) begin
            mismatched++; $display("FAIL latency_gap: valid=%b want 0", pixel_out_valid);
        end
        for (int k = 0; k < NPIX; k++) begin
            tick();
            compared++;
            if ({pixel_out_valid, done, act_tuple} !== {2'b10, exp_tuple(k)}) begin
                mismatched++; $display("FAIL full_pixel%0d: got v=%b d=%b %h want 1 0 %h",
                                       k, pixel_out_valid, done, act_tuple, exp_tuple(k));
            end
        end
        tick();
        compared++;
        if ({done, busy, pixel_out_valid} !== 3'b100) begin
            mismatched++; $display("FAIL done_pulse: got done/busy/valid=%b want 100", {done, busy, pixel_out_valid});
        end
        tick();
        compared++;
        if (done !== 1'b0) begin
            mismatched++; $display("FAIL done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int cyc = 0;
        int occ;
        bit seen;
        logic        prev_stall = 1'b0;
        logic [41:0] prev_tuple = '0;
        pixel_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        while (acc < NPIX && cyc < 200) begin
            pixel_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            #1;
            if (prev_stall) begin
                compared++;
                if (act_tuple !== prev_tuple || pixel_out_valid !== 1'b1) begin
                    mismatched++; $display("FAIL bp_hold: got %h v=%b want %h v=1", act_tuple, pixel_out_valid, prev_tuple);
                end
            end
            occ = int'(dut.fifo_count) + int'(dut.inflight) + int'(mem_rd_en) - int'(pixel_out_valid && pixel_ready);
            compared++;
            if (occ > 2) begin
                mismatched++; $display("FAIL bp_credit: pending=%0d want <=2", occ);
            end
            if (pixel_out_valid && pixel_ready) begin
                compared++;
                if (act_tuple !== exp_tuple(acc)) begin
                    mismatched++; $display("FAIL bp_pixel%0d: got %h want %h", acc, act_tuple, exp_tuple(acc));
                end
                acc++;
            end
            prev_stall = pixel_out_valid && !pixel_ready;
            prev_tuple = act_tuple;
            cyc++;
            tick();
        end
        compared++;
        if (acc != NPIX) begin
            mismatched++; $display("FAIL bp_count: got %0d pixels want %0d", acc, NPIX);
        end
        pixel_ready = 1'b1;
        wait_done(seen);
        compared++;
        if (seen !== 1'b1) begin
            mismatched++; $display("FAIL bp_done: done=%b want 1", seen);
        end
        tick();
    endtask

    task automatic test_long_stall();
        int acc = 0;
        int cyc = 0;
        int stall = 0;
        bit seen;
        pixel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (acc < NPIX && cyc < 200) begin
            pixel_ready = !(acc == 5 && stall < 20);
            #1;
            if (!pixel_ready) begin
                stall++;
                if (stall >= 2) begin
                    compared++;
                    if (dut.fifo_count !== 2'd2 || mem_rd_en !== 1'b0) begin
                        mismatched++; $display("FAIL stall_fill: count=%0d rd_en=%b want 2 0", dut.fifo_count, mem_rd_en);
                    end
                end
            end
            if (pixel_out_valid && pixel_ready) begin
                compared++;
                if (act_tuple !== exp_tuple(acc)) begin
                    mismatched++; $display("FAIL stall_pixel%0d: got %h want %h", acc, act_tuple, exp_tuple(acc));
                end
                acc++;
            end
            cyc++;
            tick();
        end
        compared++;
        if (acc != NPIX || stall != 20) begin
            mismatched++; $display("FAIL stall_count: got %0d pixels %0d stalls want %0d 20", acc, stall, NPIX);
        end
        wait_done(seen);
        compared++;
        if (seen !== 1'b1) begin
            mismatched++; $display("FAIL stall_done: done=%b want 1", seen);
        end
        tick();
    endtask

    task automatic test_start_handling();
        bit seen;
        bit extra_read = 1'b0;
        pixel_ready = 1'b1; start = 1'b1;
        tick();
        wait_done(seen);
        compared++;
        if (seen !== 1'b1) begin
            mismatched++; $display("FAIL hold_done1: done=%b want 1", seen);
        end
        tick();
        compared++;
        if ({busy, mem_rd_en, done} !== 3'b000) begin
            mismatched++; $display("FAIL hold_idle: busy/rd_en/done=%b want 000", {busy, mem_rd_en, done});
        end
        tick();
        compared++;
        if ({busy, mem_rd_en, mem_addr} !== {2'b11, 4'd0}) begin
            mismatched++; $display("FAIL hold_restart: busy/rd_en=%b addr=%0d want 11 0", {busy, mem_rd_en}, mem_addr);
        end
        start = 1'b0;
        tick(); tick();
        compared++;
        if ({pixel_out_valid, act_tuple} !== {1'b1, exp_tuple(0)}) begin
            mismatched++; $display("FAIL hold_frame2: got v=%b %h want 1 %h", pixel_out_valid, act_tuple, exp_tuple(0));
        end
        wait_done(seen);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(seen);
        compared++;
        if (seen !== 1'b1) begin
            mismatched++; $display("FAIL pulse_done: done=%b want 1", seen);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_rd_en || busy) extra_read = 1'b1;
        end
        compared++;
        if (extra_read !== 1'b0) begin
            mismatched++; $display("FAIL pulse_ignored: extra activity=%b want 0", extra_read);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        pixel_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        compared++;
        if (act_tuple !== exp_tuple(5)) begin
            mismatched++; $display("FAIL rst_pre: got %h want %h", act_tuple, exp_tuple(5));
        end
        rstN = 1'b0;
        tick();
        compared++;
        if ({mem_rd_en, mem_addr, pixel_out_valid, act_tuple, busy, done} !== '0) begin
            mismatched++; $display("FAIL rst_outputs: got %h want 0",
                                   {mem_rd_en, mem_addr, pixel_out_valid, act_tuple, busy, done});
        end
        rstN = 1'b1;
        tick();
        compared++;
        if ({pixel_out_valid, dut.fifo_count} !== 3'b000) begin
            mismatched++; $display("FAIL rst_discard: valid=%b count=%0d want 0 0", pixel_out_valid, dut.fifo_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        compared++;
        if ({pixel_out_valid, act_tuple} !== {1'b1, exp_tuple(0)}) begin
            mismatched++; $display("FAIL rst_restart: got v=%b %h want 1 %h", pixel_out_valid, act_tuple, exp_tuple(0));
        end
        wait_done(seen);
        compared++;
        if (seen !== 1'b1) begin
            mismatched++; $display("FAIL rst_done: done=%b want 1", seen);
        end
        tick();
    endtask

    task automatic test_no_overflow();
        compared++;
        if (ovf_events !== 0) begin
            mismatched++; $display("FAIL no_overflow: got %0d events want 0", ovf_events);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_long_stall();
        test_start_handling();
        test_reset_mid_frame();
        test_no_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
